uart_rx_cfg: RTL and testbench

Parametrised successor to the fixed 8N1 UART receiver.
- Configurable data width, parity mode, stop-bit count and bit period.
- Input synchroniser plus 3-sample majority vote on each bit.
- Reports parity, framing and break errors alongside each received word.
- Sits between the external RX pin and the command parser, in the same 50 MHz clock domain as the existing receiver.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_cfg_if.sv | 36 +++
 rtl/uart_rx_sampler.sv | 44 ++++
 rtl/uart_rx_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
// Holds the parity modes, the state encoding and the counter sizing helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_HIGH
    } state_e;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side signal bundle: line and enable in, received word and status out.
// The slave modport is the receiver, the master modport is whoever drives the line.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic                 rxd;
    logic [DATA_BITS-1:0] data;
    logic                 finished;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 busy;

    modport master (
        output enable,
        output rxd,
        input  data,
        input  finished,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  busy
    );

    modport slave (
        input  enable,
        input  rxd,
        output data,
        output finished,
        output parity_err,
        output frame_err,
        output break_det,
        output busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the serial line plus a 3-tap majority vote
// taken around the middle of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CW           = clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxd,
    input  logic [CW-1:0] count,
    output logic          rxd_sync,
    output logic          bit_val,
    output logic          bit_strobe
);
    localparam int            M         = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_EARLY = CW'(M - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(M);
    localparam logic [CW-1:0] CNT_LATE  = CW'(M + 1);

    logic [1:0] sync_q;
    logic       early_q;
    logic       mid_q;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            if (count == CNT_EARLY) early_q <= sync_q[1];
            if (count == CNT_MID)   mid_q   <= sync_q[1];
        end
    end

    // The third tap is the live synced value, so the decision lands at M+1.
    assign rxd_sync   = sync_q[1];
    assign bit_strobe = (count == CNT_LATE);
    assign bit_val    = (early_q & mid_q) | (early_q & rxd_sync) | (mid_q & rxd_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits and bit period are
// parameters; reports parity, framing and break errors with each word.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_cfg_if.slave rx
);
    localparam int            CW        = clog2(CLKS_PER_BIT);
    localparam int            IW        = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic [1:0]           rst_sync_q;
    logic                 rst_int;
    logic                 rxd_sync, bit_val, bit_strobe, wrap, par_expect;
    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 ones_q, ones_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 finished_q, finished_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_sampler (
        .clk        (clk),
        .reset      (rst_int),
        .rxd        (rx.rxd),
        .count      (count_q),
        .rxd_sync   (rxd_sync),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe)
    );

    assign wrap       = (count_q == CNT_LAST);
    assign par_expect = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = (state_q == ST_IDLE) ? '0 : (wrap ? '0 : count_q + CNT_ONE);
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        fe_acc_d     = fe_acc_q;
        ones_d       = ones_q;
        data_d       = data_q;
        finished_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = break_q;

        if (!rx.enable) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d     = '0;
                    par_acc_d = 1'b0;
                    fe_acc_d  = 1'b0;
                    ones_d    = 1'b0;
                    if (!rxd_sync) state_d = ST_START;
                end
                ST_START: begin
                    if (bit_strobe && bit_val) state_d = ST_IDLE;
                    else if (wrap)             state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_val) ones_d = 1'b1;
                    end
                    if (wrap) begin
                        if (idx_q == DATA_LAST) begin
                            idx_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
                ST_PAR: begin
                    if (bit_strobe) begin
                        par_acc_d = (bit_val != par_expect);
                        if (bit_val) ones_d = 1'b1;
                    end
                    if (wrap) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (bit_strobe) begin
                        if (bit_val) ones_d   = 1'b1;
                        else         fe_acc_d = 1'b1;
                        // Last stop bit decided: publish the frame on the next edge.
                        if (idx_q == STOP_LAST) begin
                            data_d       = shift_q;
                            parity_err_d = par_acc_q;
                            frame_err_d  = fe_acc_q | ~bit_val;
                            break_d      = ~ones_q & ~bit_val;
                            finished_d   = 1'b1;
                            count_d      = '0;
                            state_d      = (~ones_q & ~bit_val) ? ST_WAIT_HIGH : ST_IDLE;
                        end
                    end else if (wrap) begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!rxd_sync) count_d = '0;
                    else if (wrap) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            fe_acc_q     <= 1'b0;
            ones_q       <= 1'b0;
            data_q       <= '0;
            finished_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            fe_acc_q     <= fe_acc_d;
            ones_q       <= ones_d;
            data_q       <= data_d;
            finished_q   <= finished_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
        end
    end

    assign rx.data       = data_q;
    assign rx.finished   = finished_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.break_det  = break_q;
    assign rx.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at 8 clocks
// per bit sharing one stimulus line, selected per scenario.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB = 8;
    localparam int M   = CPB / 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b1;
    logic line  = 1'b1;
    int   sel   = 0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fin_cnt [3];
    int   fin_cyc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if_c ();

    assign if_a.enable = en;
    assign if_b.enable = en;
    assign if_c.enable = en;
    assign if_a.rxd    = (sel == 0) ? line : 1'b1;
    assign if_b.rxd    = (sel == 1) ? line : 1'b1;
    assign if_c.rxd    = (sel == 2) ? line : 1'b1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .rx(if_a));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
        dut_b (.clk(clk), .reset(reset), .rx(if_b));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2))
        dut_c (.clk(clk), .reset(reset), .rx(if_c));

    always @(negedge clk) begin
        if (if_a.finished) begin fin_cnt[0]++; fin_cyc[0] = cyc; end
        if (if_b.finished) begin fin_cnt[1]++; fin_cyc[1] = cyc; end
        if (if_c.finished) begin fin_cnt[2]++; fin_cyc[2] = cyc; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one frame (bit 0 = start bit first) from a negedge, then idles two bit periods.
    // e0 is the cycle index of the first clock edge that samples the start bit.
    task automatic send_frame(input int which, input logic [15:0] bits, input int nbits,
                              input int spike_at, output int e0);
        sel = which;
        e0  = cyc + 1;
        for (int j = 0; j < nbits; j++) begin
            for (int k = 0; k < CPB; k++) begin
                line = bits[j] ^ ((j * CPB + k) == spike_at);
                @(negedge clk);
            end
        end
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (if_a.data !== 8'h00) begin n_bad++; $display("FAIL rst_a_data got=%h exp=00", if_a.data); end
        n_cmp++; if (if_a.finished !== 1'b0) begin n_bad++; $display("FAIL rst_a_finished got=%b exp=0", if_a.finished); end
        n_cmp++; if ({if_a.parity_err, if_a.frame_err, if_a.break_det} !== 3'b000) begin n_bad++; $display("FAIL rst_a_flags got=%b exp=000", {if_a.parity_err, if_a.frame_err, if_a.break_det}); end
        n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL rst_a_busy got=%b exp=0", if_a.busy); end
        n_cmp++; if (if_c.data !== 7'h00) begin n_bad++; $display("FAIL rst_c_data got=%h exp=00", if_c.data); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({if_a.busy, if_b.busy, if_c.busy} !== 3'b000) begin n_bad++; $display("FAIL rst_busy_after got=%b exp=000", {if_a.busy, if_b.busy, if_c.busy}); end
    endtask

    task automatic test_8n1();
        int e0, f0;
        f0 = fin_cnt[0];
        send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, -1, e0);
        n_cmp++; if (if_a.data !== 8'hA5) begin n_bad++; $display("FAIL t1_data got=%h exp=a5", if_a.data); end
        n_cmp++; if (fin_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL t1_finished_cycles got=%0d exp=1", fin_cnt[0] - f0); end
        n_cmp++; if ({if_a.parity_err, if_a.frame_err, if_a.break_det} !== 3'b000) begin n_bad++; $display("FAIL t1_flags got=%b exp=000", {if_a.parity_err, if_a.frame_err, if_a.break_det}); end
        n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy got=%b exp=0", if_a.busy); end
        n_cmp++; if (fin_cyc[0] - e0 !== 2 + CPB * (1 + 8 + 0 + 1 - 1) + M + 2) begin n_bad++; $display("FAIL t1_latency got=%0d exp=%0d", fin_cyc[0] - e0, 2 + CPB * 9 + M + 2); end
    endtask

    task automatic test_parity();
        int e0, f0;
        f0 = fin_cnt[1];
        send_frame(1, {1'b1, 1'b0, 8'h37, 1'b0}, 11, -1, e0);
        n_cmp++; if (if_b.data !== 8'h37) begin n_bad++; $display("FAIL t2_bad_data got=%h exp=37", if_b.data); end
        n_cmp++; if (if_b.parity_err !== 1'b1) begin n_bad++; $display("FAIL t2_bad_parity got=%b exp=1", if_b.parity_err); end
        n_cmp++; if (fin_cyc[1] - e0 !== 2 + CPB * (1 + 8 + 1 + 1 - 1) + M + 2) begin n_bad++; $display("FAIL t2_latency got=%0d exp=%0d", fin_cyc[1] - e0, 2 + CPB * 10 + M + 2); end
        send_frame(1, {1'b1, 1'b1, 8'h37, 1'b0}, 11, -1, e0);
        n_cmp++; if (if_b.parity_err !== 1'b0) begin n_bad++; $display("FAIL t2_good_parity got=%b exp=0", if_b.parity_err); end
        n_cmp++; if ({if_b.frame_err, if_b.break_det} !== 2'b00) begin n_bad++; $display("FAIL t2_other_flags got=%b exp=00", {if_b.frame_err, if_b.break_det}); end
        n_cmp++; if (fin_cnt[1] - f0 !== 2) begin n_bad++; $display("FAIL t2_finished_count got=%0d exp=2", fin_cnt[1] - f0); end
    endtask

    task automatic test_glitch();
        int e0, f0, busy_cycles;
        f0          = fin_cnt[0];
        busy_cycles = 0;
        sel         = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (if_a.busy) busy_cycles++;
            line = (i < 2) ? 1'b0 : 1'b1;
        end
        n_cmp++; if (busy_cycles !== 6) begin n_bad++; $display("FAIL t4_false_start_busy got=%0d exp=6", busy_cycles); end
        n_cmp++; if (fin_cnt[0] - f0 !== 0) begin n_bad++; $display("FAIL t4_false_start_finished got=%0d exp=0", fin_cnt[0] - f0); end
        n_cmp++; if (if_a.data !== 8'hA5) begin n_bad++; $display("FAIL t4_data_held got=%h exp=a5", if_a.data); end
        n_cmp++; if ({if_a.parity_err, if_a.frame_err, if_a.break_det} !== 3'b000) begin n_bad++; $display("FAIL t4_flags_held got=%b exp=000", {if_a.parity_err, if_a.frame_err, if_a.break_det}); end
        send_frame(0, {1'b1, 8'h00, 1'b0}, 10, 5 * CPB + 5, e0);
        n_cmp++; if (if_a.data !== 8'h00) begin n_bad++; $display("FAIL t4_spike_data got=%h exp=00", if_a.data); end
        n_cmp++; if (fin_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL t4_spike_finished got=%0d exp=1", fin_cnt[0] - f0); end
        n_cmp++; if ({if_a.parity_err, if_a.frame_err, if_a.break_det} !== 3'b000) begin n_bad++; $display("FAIL t4_spike_flags got=%b exp=000", {if_a.parity_err, if_a.frame_err, if_a.break_det}); end
    endtask

    task automatic test_frame_break();
        int e0, f0, busy_cycles;
        send_frame(0, {1'b0, 8'h55, 1'b0}, 10, -1, e0);
        n_cmp++; if (if_a.frame_err !== 1'b1) begin n_bad++; $display("FAIL t3_frame_err got=%b exp=1", if_a.frame_err); end
        n_cmp++; if (if_a.data !== 8'h55) begin n_bad++; $display("FAIL t3_frame_data got=%h exp=55", if_a.data); end
        n_cmp++; if (if_a.break_det !== 1'b0) begin n_bad++; $display("FAIL t3_frame_nobreak got=%b exp=0", if_a.break_det); end
        f0   = fin_cnt[0];
        sel  = 0;
        line = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        n_cmp++; if (fin_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL t3_break_finished got=%0d exp=1", fin_cnt[0] - f0); end
        n_cmp++; if ({if_a.frame_err, if_a.break_det} !== 2'b11) begin n_bad++; $display("FAIL t3_break_flags got=%b exp=11", {if_a.frame_err, if_a.break_det}); end
        n_cmp++; if (if_a.data !== 8'h00) begin n_bad++; $display("FAIL t3_break_data got=%h exp=00", if_a.data); end
        n_cmp++; if (if_a.busy !== 1'b1) begin n_bad++; $display("FAIL t3_break_busy got=%b exp=1", if_a.busy); end
        line        = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (if_a.busy) busy_cycles++;
        end
        n_cmp++; if (busy_cycles !== CPB + 1) begin n_bad++; $display("FAIL t3_wait_high_cycles got=%0d exp=%0d", busy_cycles, CPB + 1); end
        n_cmp++; if (fin_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL t3_no_rearm got=%0d exp=1", fin_cnt[0] - f0); end
    endtask

    task automatic test_enable_abort();
        int e0, f0;
        f0 = fin_cnt[0];
        fork
            send_frame(0, {1'b1, 8'hFF, 1'b0}, 10, -1, e0);
            begin
                repeat (30) @(negedge clk);
                n_cmp++; if (if_a.busy !== 1'b1) begin n_bad++; $display("FAIL en_busy_before got=%b exp=1", if_a.busy); end
                en = 1'b0;
                @(negedge clk);
                n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL en_abort_idle got=%b exp=0", if_a.busy); end
                en = 1'b1;
            end
        join
        n_cmp++; if (fin_cnt[0] - f0 !== 0) begin n_bad++; $display("FAIL en_no_finished got=%0d exp=0", fin_cnt[0] - f0); end
        n_cmp++; if ({if_a.data, if_a.frame_err, if_a.break_det} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL en_outputs_held got=%h exp=003", {if_a.data, if_a.frame_err, if_a.break_det}); end
    endtask

    task automatic test_reset_midframe();
        int e0, f0;
        fork
            send_frame(0, {1'b1, 8'hFF, 1'b0}, 10, -1, e0);
            begin
                repeat (4 * CPB + M) @(negedge clk);
                n_cmp++; if (if_a.busy !== 1'b1) begin n_bad++; $display("FAIL t5_busy_before got=%b exp=1", if_a.busy); end
                reset = 1'b1;
                #1;
                n_cmp++; if ({if_a.data, if_a.finished, if_a.parity_err, if_a.frame_err, if_a.break_det, if_a.busy} !== 13'h0) begin n_bad++; $display("FAIL t5_reset_clear got=%h exp=0000", {if_a.data, if_a.finished, if_a.parity_err, if_a.frame_err, if_a.break_det, if_a.busy}); end
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        f0 = fin_cnt[0];
        send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, -1, e0);
        n_cmp++; if (if_a.data !== 8'h5A) begin n_bad++; $display("FAIL t5_data got=%h exp=5a", if_a.data); end
        n_cmp++; if ({if_a.parity_err, if_a.frame_err, if_a.break_det} !== 3'b000) begin n_bad++; $display("FAIL t5_flags got=%b exp=000", {if_a.parity_err, if_a.frame_err, if_a.break_det}); end
        n_cmp++; if (fin_cnt[0] - f0 !== 1) begin n_bad++; $display("FAIL t5_finished got=%0d exp=1", fin_cnt[0] - f0); end
    endtask

    task automatic test_7o2();
        int e0, f0;
        f0 = fin_cnt[2];
        send_frame(2, {2'b11, 1'b1, 7'h41, 1'b0}, 11, -1, e0);
        n_cmp++; if (if_c.data !== 7'h41) begin n_bad++; $display("FAIL t6_data got=%h exp=41", if_c.data); end
        n_cmp++; if ({if_c.parity_err, if_c.frame_err, if_c.break_det} !== 3'b000) begin n_bad++; $display("FAIL t6_flags got=%b exp=000", {if_c.parity_err, if_c.frame_err, if_c.break_det}); end
        n_cmp++; if (fin_cyc[2] - e0 !== 2 + CPB * (1 + 7 + 1 + 2 - 1) + M + 2) begin n_bad++; $display("FAIL t6_latency got=%0d exp=%0d", fin_cyc[2] - e0, 2 + CPB * 10 + M + 2); end
        send_frame(2, {2'b01, 1'b1, 7'h41, 1'b0}, 11, -1, e0);
        n_cmp++; if ({if_c.parity_err, if_c.frame_err, if_c.break_det} !== 3'b010) begin n_bad++; $display("FAIL t6_stop2_flags got=%b exp=010", {if_c.parity_err, if_c.frame_err, if_c.break_det}); end
        n_cmp++; if (if_c.data !== 7'h41) begin n_bad++; $display("FAIL t6_stop2_data got=%h exp=41", if_c.data); end
        n_cmp++; if (fin_cyc[2] - e0 !== 2 + CPB * (1 + 7 + 1 + 2 - 1) + M + 2) begin n_bad++; $display("FAIL t6_stop2_latency got=%0d exp=%0d", fin_cyc[2] - e0, 2 + CPB * 10 + M + 2); end
        n_cmp++; if (fin_cnt[2] - f0 !== 2) begin n_bad++; $display("FAIL t6_finished_count got=%0d exp=2", fin_cnt[2] - f0); end
        n_cmp++; if (if_c.busy !== 1'b0) begin n_bad++; $display("FAIL t6_busy got=%b exp=0", if_c.busy); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_break();
        test_enable_abort();
        test_reset_midframe();
        test_7o2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
